// File: rtl/tile_stream_mem.sv
// tile_stream_mem: tile-wide array memory with streaming block loader and thread read engines
module tile_stream_mem #(
  parameter int ADDRSIZE  = 64,
  parameter int BITWIDTH  = 8,
  parameter int MESHUNITS = 2,
  parameter int TILEUNITS = 2,
  parameter int LOADBEAT  = 2
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic        [MESHUNITS-1:0][BITWIDTH-1:0]              rd_addr,
  input  logic        [MESHUNITS-1:0]                            rd_req,
  output logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] rd_data,
  output logic        [MESHUNITS-1:0]                            rd_valid,
  input  logic        [MESHUNITS-1:0][BITWIDTH-1:0]              wr_addr,
  input  logic        [MESHUNITS-1:0]                            wr_valid,
  input  logic        [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] wr_data,
  input  logic                                                   ld_start,
  input  logic        [BITWIDTH-1:0]                             ld_addr,
  output logic                                                   ld_ready,
  input  logic                                                   ld_beat_valid,
  input  logic        [LOADBEAT-1:0][BITWIDTH-1:0]               ld_beat_data,
  output logic                                                   ld_busy,
  output logic                                                   ld_done,
  input  logic                                                   th_start,
  input  logic        [BITWIDTH-1:0]                             th_addr,
  output logic                                                   th_valid,
  input  logic                                                   th_ready,
  output logic signed [LOADBEAT-1:0][BITWIDTH-1:0]               th_data,
  output logic                                                   th_last
);
  localparam int BLOCK_SIZE = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
  localparam int NBEATS     = BLOCK_SIZE / LOADBEAT;
  localparam int AW         = $clog2(ADDRSIZE);
  localparam int CW         = NBEATS > 1 ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;
  typedef enum logic {T_IDLE, T_STREAM} th_state_t;

  function automatic logic [AW-1:0] tile_base(input logic [BITWIDTH-1:0] a);
    return AW'(a & ~BITWIDTH'(TILEUNITS - 1));
  endfunction

  function automatic logic [AW-1:0] block_base(input logic [BITWIDTH-1:0] a);
    return AW'(a & ~BITWIDTH'(BLOCK_SIZE - 1));
  endfunction

  function automatic logic [AW-1:0] beat_word(input logic [AW-1:0] base, input logic [CW-1:0] cnt, input int k);
    return base + AW'(int'(cnt) * LOADBEAT + k);
  endfunction

  logic [BITWIDTH-1:0] mem [ADDRSIZE];

  ld_state_t      ld_state, ld_next;
  logic [CW-1:0]  ld_cnt;
  logic [AW-1:0]  ld_base;
  logic           ld_accept;

  th_state_t      th_state, th_next;
  logic [CW-1:0]  th_cnt;
  logic [AW-1:0]  th_base;
  logic           th_fire;

  assign ld_accept = ld_beat_valid & ld_ready;
  assign th_fire   = th_valid & th_ready;

  always_ff @(posedge clock)
    ld_state <= reset ? L_IDLE : ld_next;

  always_comb
    ld_next = (ld_state == L_IDLE && ld_start) ? L_LOAD :
              (ld_state == L_LOAD && ld_accept && ld_cnt == CW'(NBEATS - 1)) ? L_DONE :
              (ld_state == L_DONE) ? L_IDLE : ld_state;

  always_comb begin
    ld_ready = ld_state == L_LOAD;
    ld_busy  = ld_state != L_IDLE;
    ld_done  = ld_state == L_DONE;
  end

  always_ff @(posedge clock)
    if (reset) begin
      ld_cnt  <= '0;
      ld_base <= '0;
    end else if (ld_state == L_IDLE && ld_start) begin
      ld_cnt  <= '0;
      ld_base <= block_base(ld_addr);
    end else if (ld_accept) begin
      ld_cnt  <= ld_cnt + 1'b1;
    end

  always_ff @(posedge clock)
    th_state <= reset ? T_IDLE : th_next;

  always_comb
    th_next = (th_state == T_IDLE && th_start) ? T_STREAM :
              (th_fire && th_cnt == CW'(NBEATS - 1)) ? T_IDLE : th_state;

  always_comb begin
    th_valid = th_state == T_STREAM;
    th_last  = th_valid && th_cnt == CW'(NBEATS - 1);
  end

  always_ff @(posedge clock)
    if (reset) begin
      th_cnt  <= '0;
      th_base <= '0;
      th_data <= '0;
    end else if (th_state == T_IDLE && th_start) begin
      th_cnt  <= '0;
      th_base <= block_base(th_addr);
      for (int k = 0; k < LOADBEAT; k++) th_data[k] <= mem[beat_word(block_base(th_addr), '0, k)];
    end else if (th_fire && !th_last) begin
      th_cnt  <= th_cnt + 1'b1;
      for (int k = 0; k < LOADBEAT; k++) th_data[k] <= mem[beat_word(th_base, th_cnt + 1'b1, k)];
    end

  always_ff @(posedge clock)
    if (reset) begin
      for (int w = 0; w < ADDRSIZE; w++) mem[w] <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int i = 0; i < MESHUNITS; i++) begin
        rd_valid[i] <= rd_req[i];
        if (rd_req[i])
          for (int j = 0; j < TILEUNITS; j++) rd_data[i][j] <= mem[tile_base(rd_addr[i]) + AW'(j)];
        if (wr_valid[i])
          for (int j = 0; j < TILEUNITS; j++) mem[tile_base(wr_addr[i]) + AW'(j)] <= wr_data[i][j];
      end
      if (ld_accept)
        for (int k = 0; k < LOADBEAT; k++) mem[beat_word(ld_base, ld_cnt, k)] <= ld_beat_data[k];
    end
endmodule

// File: tb/tb_tile_stream_mem.sv
// tb_tile_stream_mem: directed self-checking bench for tile_stream_mem
module tb_tile_stream_mem;
  logic                     clock = 0;
  logic                     reset;
  logic        [1:0][7:0]   rd_addr;
  logic        [1:0]        rd_req;
  logic signed [1:0][1:0][7:0] rd_data;
  logic        [1:0]        rd_valid;
  logic        [1:0][7:0]   wr_addr;
  logic        [1:0]        wr_valid;
  logic        [1:0][1:0][7:0] wr_data;
  logic                     ld_start;
  logic        [7:0]        ld_addr;
  logic                     ld_ready;
  logic                     ld_beat_valid;
  logic        [1:0][7:0]   ld_beat_data;
  logic                     ld_busy;
  logic                     ld_done;
  logic                     th_start;
  logic        [7:0]        th_addr;
  logic                     th_valid;
  logic                     th_ready;
  logic signed [1:0][7:0]   th_data;
  logic                     th_last;

  int checks = 0;
  int errors = 0;

  tile_stream_mem dut (
    .clock(clock), .reset(reset),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_data(wr_data),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_beat_valid(ld_beat_valid),
    .ld_beat_data(ld_beat_data), .ld_busy(ld_busy), .ld_done(ld_done),
    .th_start(th_start), .th_addr(th_addr), .th_valid(th_valid), .th_ready(th_ready),
    .th_data(th_data), .th_last(th_last)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    tick();
    tick();
    reset = 0;
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset_rd_valid got %b exp 00", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL reset_ld_busy got %b exp 0", ld_busy); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_ld_done got %b exp 0", ld_done); end
    checks++; if (th_valid !== 1'b0) begin errors++; $display("FAIL reset_th_valid got %b exp 0", th_valid); end
    checks++; if (th_last !== 1'b0) begin errors++; $display("FAIL reset_th_last got %b exp 0", th_last); end
    checks++; if (th_data !== 16'h0) begin errors++; $display("FAIL reset_th_data got %h exp 0", th_data); end
  endtask

  task automatic test_read;
    rd_req = 2'b01;
    rd_addr[0] = 8'd5;
    tick();
    rd_req = 2'b00;
    checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("FAIL read_valid got %b exp 1", rd_valid[0]); end
    checks++; if (rd_data[0] !== 16'h0) begin errors++; $display("FAIL read_data got %h exp 0", rd_data[0]); end
    tick();
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL read_idle_valid got %b exp 0", rd_valid[0]); end
    checks++; if (rd_data[0] !== 16'h0) begin errors++; $display("FAIL read_idle_data got %h exp 0", rd_data[0]); end
  endtask

  task automatic test_write;
    wr_valid = 2'b01;
    wr_addr[0] = 8'd7;
    wr_data[0] = 16'hFC03;
    rd_req = 2'b10;
    rd_addr[1] = 8'd6;
    tick();
    wr_valid = 2'b00;
    checks++; if (rd_valid[1] !== 1'b1) begin errors++; $display("FAIL rbw_valid got %b exp 1", rd_valid[1]); end
    checks++; if (rd_data[1] !== 16'h0) begin errors++; $display("FAIL rbw_data got %h exp 0", rd_data[1]); end
    tick();
    rd_req = 2'b00;
    checks++; if (rd_data[1] !== 16'hFC03) begin errors++; $display("FAIL write_data got %h exp fc03", rd_data[1]); end
    wr_valid = 2'b10;
    wr_addr[1] = 8'h42;
    wr_data[1] = 16'h2211;
    tick();
    wr_valid = 2'b00;
    rd_req = 2'b01;
    rd_addr[0] = 8'd2;
    tick();
    rd_req = 2'b00;
    checks++; if (rd_data[0] !== 16'h2211) begin errors++; $display("FAIL wrap_data got %h exp 2211", rd_data[0]); end
    tick();
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL hold_valid got %b exp 0", rd_valid[0]); end
    checks++; if (rd_data[0] !== 16'h2211) begin errors++; $display("FAIL hold_data got %h exp 2211", rd_data[0]); end
  endtask

  task automatic test_priority;
    ld_addr = 8'd0;
    ld_start = 1;
    tick();
    ld_start = 0;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL prio_ld_ready got %b exp 1", ld_ready); end
    checks++; if (ld_busy !== 1'b1) begin errors++; $display("FAIL prio_ld_busy got %b exp 1", ld_busy); end
    ld_beat_valid = 1;
    ld_beat_data = 16'hA0A0;
    for (int b = 0; b < 5; b++) tick();
    ld_beat_data = 16'h0902;
    wr_valid = 2'b11;
    wr_addr[0] = 8'd10;
    wr_addr[1] = 8'd10;
    wr_data[0] = 16'h0101;
    wr_data[1] = 16'h0202;
    tick();
    ld_beat_valid = 0;
    wr_addr[0] = 8'd4;
    wr_addr[1] = 8'd4;
    tick();
    wr_valid = 2'b00;
    ld_beat_valid = 1;
    ld_beat_data = 16'hA0A0;
    tick();
    tick();
    ld_beat_valid = 0;
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL prio_ld_done got %b exp 1", ld_done); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL prio_done_ready got %b exp 0", ld_ready); end
    tick();
    checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL prio_idle_busy got %b exp 0", ld_busy); end
    rd_req = 2'b11;
    rd_addr[0] = 8'd11;
    rd_addr[1] = 8'd4;
    tick();
    rd_req = 2'b00;
    checks++; if (rd_data[0] !== 16'h0902) begin errors++; $display("FAIL prio_loader got %h exp 0902", rd_data[0]); end
    checks++; if (rd_data[1] !== 16'h0202) begin errors++; $display("FAIL prio_channel got %h exp 0202", rd_data[1]); end
  endtask

  task automatic test_load;
    logic [15:0] exp;
    ld_addr = 8'h13;
    ld_start = 1;
    tick();
    ld_start = 0;
    for (int k = 0; k < 8; k++) begin
      ld_beat_valid = 1;
      ld_beat_data = {8'(2 * k + 1), 8'(2 * k)};
      tick();
      checks++; if (ld_done !== (k == 7)) begin errors++; $display("FAIL load_done_beat%0d got %b exp %b", k, ld_done, k == 7); end
      ld_beat_valid = 0;
      ld_start = (k == 3);
      ld_addr = 8'd0;
      tick();
      ld_start = 0;
      checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL load_done_gap%0d got %b exp 0", k, ld_done); end
      checks++; if (ld_busy !== (k != 7)) begin errors++; $display("FAIL load_busy_gap%0d got %b exp %b", k, ld_busy, k != 7); end
    end
    for (int t = 0; t < 8; t++) begin
      rd_req = 2'b01;
      rd_addr[0] = 8'(16 + 2 * t);
      tick();
      exp = {8'(2 * t + 1), 8'(2 * t)};
      checks++; if (rd_data[0] !== exp) begin errors++; $display("FAIL load_word%0d got %h exp %h", 16 + 2 * t, rd_data[0], exp); end
    end
    rd_req = 2'b00;
  endtask

  task automatic test_stream;
    logic [15:0] exp;
    th_addr = 8'd16;
    th_start = 1;
    th_ready = 0;
    tick();
    th_start = 0;
    for (int h = 0; h < 4; h++) begin
      checks++; if (th_valid !== 1'b1) begin errors++; $display("FAIL stream_hold_valid%0d got %b exp 1", h, th_valid); end
      checks++; if (th_data !== 16'h0100) begin errors++; $display("FAIL stream_hold_data%0d got %h exp 0100", h, th_data); end
      if (h < 3) tick();
    end
    th_ready = 1;
    for (int b = 0; b < 8; b++) begin
      exp = {8'(2 * b + 1), 8'(2 * b)};
      checks++; if (th_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b exp 1", b, th_valid); end
      checks++; if (th_data !== exp) begin errors++; $display("FAIL stream_data%0d got %h exp %h", b, th_data, exp); end
      checks++; if (th_last !== (b == 7)) begin errors++; $display("FAIL stream_last%0d got %b exp %b", b, th_last, b == 7); end
      th_start = (b == 4);
      th_addr = 8'd0;
      tick();
    end
    th_start = 0;
    th_ready = 0;
    checks++; if (th_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b exp 0", th_valid); end
    checks++; if (th_last !== 1'b0) begin errors++; $display("FAIL stream_end_last got %b exp 0", th_last); end
  endtask

  task automatic test_reset_abort;
    ld_addr = 8'h20;
    ld_start = 1;
    tick();
    ld_start = 0;
    ld_beat_valid = 1;
    ld_beat_data = 16'h5555;
    th_addr = 8'd16;
    th_start = 1;
    tick();
    th_start = 0;
    th_ready = 1;
    tick();
    tick();
    tick();
    th_ready = 0;
    checks++; if (th_data !== 16'h0706) begin errors++; $display("FAIL abort_pre_data got %h exp 0706", th_data); end
    checks++; if (ld_busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b exp 1", ld_busy); end
    reset = 1;
    tick();
    reset = 0;
    ld_beat_valid = 0;
    checks++; if (th_valid !== 1'b0) begin errors++; $display("FAIL abort_th_valid got %b exp 0", th_valid); end
    checks++; if (th_data !== 16'h0) begin errors++; $display("FAIL abort_th_data got %h exp 0", th_data); end
    checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL abort_ld_busy got %b exp 0", ld_busy); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL abort_ld_done got %b exp 0", ld_done); end
    tick();
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", ld_done); end
    checks++; if (th_valid !== 1'b0) begin errors++; $display("FAIL abort_no_beat got %b exp 0", th_valid); end
    for (int a = 0; a < 64; a += 4) begin
      rd_req = 2'b11;
      rd_addr[0] = 8'(a);
      rd_addr[1] = 8'(a + 2);
      tick();
      checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL abort_clear_word%0d got %h exp 0", a, rd_data); end
    end
    rd_req = 2'b00;
  endtask

  initial begin
    reset = 1;
    rd_addr = '0; rd_req = '0; wr_addr = '0; wr_valid = '0; wr_data = '0;
    ld_start = 0; ld_addr = '0; ld_beat_valid = 0; ld_beat_data = '0;
    th_start = 0; th_addr = '0; th_ready = 0;
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_load();
    test_stream();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
